fft_out_reorder: RTL and testbench

- Output end of the 512-point, 16-lane FFT pipeline.
- The final butterfly/twiddle stage writes 16 samples per cycle in bit-reversed bin order. This block reads them back to the downstream consumer in natural bin order, 16 bins per cycle.
- It is a ping-pong (two-bank) frame buffer with independent write and read FSMs, so back-to-back frames stream without stalls.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_reorder_bank.sv | 38 +++
 rtl/fft_out_reorder.sv | 190 +++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, bit-reverse helper and FSM state types
// for the FFT output reorder buffer (fft_out_reorder).
package fft_pkg;

  localparam int N_POINTS = 512;
  localparam int LANES    = 16;
  localparam int BEATS    = 32;
  localparam int ADDR_W   = 9;

  typedef enum logic {W_IDLE, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;

  function automatic logic [ADDR_W-1:0] bitrev9(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one 512-entry re/im bank. 16-lane scatter write of
// beat wr_beat at bit-reversed addresses; 16-lane contiguous read of block rd_blk.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [4:0]              wr_beat,
  input  logic signed [WIDTH-1:0] wr_re [0:LANES-1],
  input  logic signed [WIDTH-1:0] wr_im [0:LANES-1],
  input  logic [4:0]              rd_blk,
  output logic signed [WIDTH-1:0] rd_re [0:LANES-1],
  output logic signed [WIDTH-1:0] rd_im [0:LANES-1]
);

  logic signed [WIDTH-1:0] mem_re [N_POINTS];
  logic signed [WIDTH-1:0] mem_im [N_POINTS];

  // Storage only: contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re[bitrev9({wr_beat, 4'(l)})] <= wr_re[l];
        mem_im[bitrev9({wr_beat, 4'(l)})] <= wr_im[l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_re[l] = mem_re[{rd_blk, 4'(l)}];
      rd_im[l] = mem_im[{rd_blk, 4'(l)}];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT output beats
// into natural-order beats. Ports: din_* in, dout_*/dout_blk/dout_last out;
// err_gap output exists only when FFT_REORDER_ERR_EN is defined.
module fft_out_reorder #(
  parameter int WIDTH    = 13,
  parameter int LANES    = 16,
  parameter int N_POINTS = 512
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] din_re [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_im [0:LANES-1],
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout_re [0:LANES-1],
  output logic signed [WIDTH-1:0] dout_im [0:LANES-1],
  output logic                    dout_valid,
  output logic [4:0]              dout_blk,
  output logic                    dout_last
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic                    err_gap
`endif
);

  import fft_pkg::*;

  localparam logic [4:0] LAST = 5'(N_POINTS / LANES - 1);

  wr_state_e  wr_state_q, wr_state_d;
  logic [4:0] wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] bank_full_q, bank_full_d;
  rd_state_e  rd_state_q, rd_state_d;
  logic [4:0] rd_cnt_q, rd_cnt_d;
  logic       rd_bank_q, rd_bank_d;

  logic signed [WIDTH-1:0] dout_re_q [0:LANES-1];
  logic signed [WIDTH-1:0] dout_re_d [0:LANES-1];
  logic signed [WIDTH-1:0] dout_im_q [0:LANES-1];
  logic signed [WIDTH-1:0] dout_im_d [0:LANES-1];
  logic       dout_valid_q, dout_valid_d;
  logic       dout_last_q, dout_last_d;
  logic [4:0] dout_blk_q, dout_blk_d;

  logic       wr_done, rd_done;
  logic [1:0] we;
  logic signed [WIDTH-1:0] b_re [0:1][0:LANES-1];
  logic signed [WIDTH-1:0] b_im [0:1][0:LANES-1];

  for (genvar k = 0; k < 2; k++) begin : g_bank
    fft_reorder_bank #(.WIDTH(WIDTH)) u_bank (
      .clk     (clk),
      .we      (we[k]),
      .wr_beat (wr_cnt_q),
      .wr_re   (din_re),
      .wr_im   (din_im),
      .rd_blk  (rd_cnt_q),
      .rd_re   (b_re[k]),
      .rd_im   (b_im[k])
    );
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    wr_done    = 1'b0;
    we         = '0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (din_valid) begin
          we[wr_bank_q] = 1'b1;
          wr_cnt_d      = 5'd1;
          wr_state_d    = W_FILL;
        end
      end
      W_FILL: begin
        if (din_valid) begin
          we[wr_bank_q] = 1'b1;
          if (wr_cnt_q == LAST) begin
            wr_done    = 1'b1;
            wr_cnt_d   = '0;
            wr_bank_d  = ~wr_bank_q;
            wr_state_d = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    rd_done      = 1'b0;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    dout_blk_d   = dout_blk_q;
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_state_d = R_DRAIN;
          rd_cnt_d   = '0;
        end
      end
      R_DRAIN: begin
        dout_valid_d = 1'b1;
        dout_blk_d   = rd_cnt_q;
        dout_re_d    = b_re[rd_bank_q];
        dout_im_d    = b_im[rd_bank_q];
        if (rd_cnt_q == LAST) begin
          dout_last_d = 1'b1;
          rd_done     = 1'b1;
          rd_bank_d   = ~rd_bank_q;
          rd_cnt_d    = '0;
          // Chain straight into the other bank if it is already waiting.
          if (!bank_full_q[~rd_bank_q]) rd_state_d = R_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  // Set and clear always hit different banks, so ordering is harmless.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_done) bank_full_d[rd_bank_q] = 1'b0;
    if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_q   <= W_IDLE;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= '0;
      rd_state_q   <= R_IDLE;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_blk_q   <= '0;
      dout_re_q    <= '{default: '0};
      dout_im_q    <= '{default: '0};
    end else begin
      wr_state_q   <= wr_state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      rd_state_q   <= rd_state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_bank_q    <= rd_bank_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_blk_q   <= dout_blk_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
    end
  end

  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_valid = dout_valid_q;
  assign dout_blk   = dout_blk_q;
  assign dout_last  = dout_last_q;

`ifdef FFT_REORDER_ERR_EN
  logic err_gap_q, err_gap_d;

  always_comb begin
    err_gap_d = err_gap_q;
    if (wr_state_q == W_FILL && !din_valid) err_gap_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_gap_q <= 1'b0;
    else       err_gap_q <= err_gap_d;
  end

  assign err_gap = err_gap_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed bench for fft_out_reorder; a negedge
// monitor checks every output beat against the natural-order ramp.
module tb_fft_out_reorder;

  logic clk = 1'b0;
  logic rstn;
  logic signed [12:0] din_re [0:15];
  logic signed [12:0] din_im [0:15];
  logic din_valid;
  logic signed [12:0] dout_re [0:15];
  logic signed [12:0] dout_im [0:15];
  logic dout_valid;
  logic [4:0] dout_blk;
  logic dout_last;
`ifdef FFT_REORDER_ERR_EN
  logic err_gap;
`endif

  fft_out_reorder dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_blk   (dout_blk),
    .dout_last  (dout_last)
`ifdef FFT_REORDER_ERR_EN
    ,
    .err_gap    (err_gap)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;
  int mon_blk = 0;
  int mon_frame = 0;
  int n_sent = 0;
  int t_last = 0;
  int exp_off [8];
  int first_edge [8];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int brev9(input int a);
    int r = 0;
    for (int i = 0; i < 9; i++) if (a[i]) r |= 1 << (8 - i);
    return r;
  endfunction

  // Monitor: edge counter plus per-beat data checks at the negedge.
  // A reset mid-readout abandons the frame being drained.
  always begin
    @(posedge clk);
    edge_n++;
    if (!rstn && mon_blk != 0) begin
      mon_blk = 0;
      mon_frame++;
    end
    @(negedge clk);
    if (dout_valid) begin
      if (mon_frame >= n_sent) begin
        chk("spurious_valid", 1, 0);
      end else begin
        if (mon_blk == 0) first_edge[mon_frame] = edge_n;
        chk("blk", int'(dout_blk), mon_blk);
        chk("last", int'(dout_last), int'(mon_blk == 31));
        for (int l = 0; l < 16; l++) begin
          chk("re", int'(dout_re[l]), exp_off[mon_frame] + mon_blk * 16 + l);
          chk("im", int'(dout_im[l]), -(exp_off[mon_frame] + mon_blk * 16 + l));
        end
        if (mon_blk == 31) begin
          mon_blk = 0;
          mon_frame++;
        end else begin
          mon_blk++;
        end
      end
    end
  end

  task automatic send(input int off, input int gap_at, input int gap_len);
    exp_off[n_sent] = off;
    n_sent++;
    for (int c = 0; c < 32; c++) begin
      din_valid = 1'b1;
      for (int l = 0; l < 16; l++) begin
        din_re[l] = 13'(brev9(c * 16 + l) + off);
        din_im[l] = 13'(-(brev9(c * 16 + l) + off));
      end
      @(posedge clk);
      #1;
      if (c == gap_at) begin
        din_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk);
          #1;
`ifdef FFT_REORDER_ERR_EN
          if (g == 0) chk("err_gap_set", int'(err_gap), 1);
`endif
        end
      end
    end
    din_valid = 1'b0;
    t_last = edge_n;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 400 && mon_frame < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (mon_frame < target) chk("timeout", mon_frame, target);
  endtask

  initial begin
    rstn = 1'b0;
    din_valid = 1'b0;
    for (int l = 0; l < 16; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_last", int'(dout_last), 0);
    chk("rst_blk", int'(dout_blk), 0);
    chk("rst_re0", int'(dout_re[0]), 0);
`ifdef FFT_REORDER_ERR_EN
    chk("rst_err_gap", int'(err_gap), 0);
`endif
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single frame and latency.
    send(0, -1, 0);
    wait_frames(1);
    chk("latency_f0", first_edge[0] - t_last, 2);
    @(negedge clk);
    chk("valid_after_f0", int'(dout_valid), 0);

    // Three back-to-back frames.
    send(0, -1, 0);
    send(1000, -1, 0);
    send(2000, -1, 0);
    wait_frames(4);
    chk("b2b_gap_12", first_edge[2] - first_edge[1], 32);
    chk("b2b_gap_23", first_edge[3] - first_edge[2], 32);
    chk("latency_f3", first_edge[3] - t_last, 2);
    @(negedge clk);
    chk("valid_after_b2b", int'(dout_valid), 0);

    // Input gap of 3 cycles after beat 10.
    repeat (4) @(posedge clk);
    #1;
`ifdef FFT_REORDER_ERR_EN
    chk("err_gap_clear", int'(err_gap), 0);
`endif
    send(300, 10, 3);
    wait_frames(5);
    chk("latency_gap", first_edge[4] - t_last, 2);

    // Reset during readout beat 5, then a fresh frame.
    repeat (4) @(posedge clk);
    #1;
    send(500, -1, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
        @(negedge clk);
        if (dout_valid && dout_blk == 5'd5) seen = 1;
      end
      chk("reach_beat5", seen, 1);
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", int'(dout_valid), 0);
    chk("rst_mid_re0", int'(dout_re[0]), 0);
    chk("rst_mid_im15", int'(dout_im[15]), 0);
`ifdef FFT_REORDER_ERR_EN
    chk("rst_mid_err_gap", int'(err_gap), 0);
`endif
    chk("frame_abandoned", mon_frame, 6);
    @(posedge clk);
    #1;
    send(700, -1, 0);
    wait_frames(7);
    chk("latency_post_rst", first_edge[6] - t_last, 2);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
